// File: rtl/camera_pkg.sv
// Shared encodings, colour-bar table and YUV clamp limits for the camera test-pattern generator.
package camera_pkg;

    typedef enum logic [1:0] {
        MODE_BARS    = 2'b00,
        MODE_RAMP    = 2'b01,
        MODE_SOLID   = 2'b10,
        MODE_CHECKER = 2'b11
    } mode_e;

    typedef enum logic {
        FMT_YUV422 = 1'b0,
        FMT_RGB565 = 1'b1
    } fmt_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam logic [7:0] Y_MIN = 8'd16;
    localparam logic [7:0] Y_MAX = 8'd235;
    localparam logic [7:0] C_MIN = 8'd16;
    localparam logic [7:0] C_MAX = 8'd240;

    // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return 24'hFFFFFF;
            3'd1:    return 24'hFFFF00;
            3'd2:    return 24'h00FFFF;
            3'd3:    return 24'h00FF00;
            3'd4:    return 24'hFF00FF;
            3'd5:    return 24'hFF0000;
            3'd6:    return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [7:0] clamp8(input logic signed [17:0] val,
                                          input logic [7:0] lo,
                                          input logic [7:0] hi);
        if (val < $signed({10'd0, lo}))
            return lo;
        else if (val > $signed({10'd0, hi}))
            return hi;
        else
            return val[7:0];
    endfunction

endpackage

// File: rtl/camera_rgb2yuv.sv
// Combinational BT.601-style RGB to YUV conversion with floor rounding and studio-range clamping.
module camera_rgb2yuv
    import camera_pkg::*;
(
    input  rgb_t       rgb,
    output logic [7:0] y,
    output logic [7:0] u,
    output logic [7:0] v
);

    logic signed [17:0] rs, gs, bs;
    logic signed [17:0] y_t, u_t, v_t;

    always_comb begin
        rs = $signed({10'd0, rgb.r});
        gs = $signed({10'd0, rgb.g});
        bs = $signed({10'd0, rgb.b});
        // Arithmetic shift of a signed sum rounds toward minus infinity, as the chroma terms need.
        y_t = (18'sd66 * rs + 18'sd129 * gs + 18'sd25 * bs) >>> 8;
        u_t = (18'sd112 * bs - 18'sd38 * rs - 18'sd74 * gs) >>> 8;
        v_t = (18'sd112 * rs - 18'sd94 * gs - 18'sd18 * bs) >>> 8;
        y   = clamp8(y_t + 18'sd16, Y_MIN, Y_MAX);
        u   = clamp8(u_t + 18'sd128, C_MIN, C_MAX);
        v   = clamp8(v_t + 18'sd128, C_MIN, C_MAX);
    end

endmodule

// File: rtl/camera_pattern_gen.sv
// Camera-style DVP test-pattern source (bars, ramp, solid, checker) in YUV422 or RGB565.
// Define CAMERA_PATTERN_GEN_SCROLL_EN to scroll the pattern one pixel left per frame.
module camera_pattern_gen
    import camera_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 320,
    parameter int V_FP     = 8,
    parameter int V_PW     = 4,
    parameter int V_BP     = 8
) (
    input  logic        PCLK,
    input  logic        ARESETN,
    input  logic        ENABLE,
    input  logic [1:0]  MODE,
    input  logic        FMT,
    input  logic [23:0] SOLID_RGB,
    output logic        HREF,
    output logic        VSYNC,
    output logic [7:0]  CAMDATA,
    output logic [15:0] FRAME_CNT
);

    localparam int H_TOTAL = 2 * H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_FP + V_PW + V_BP + V_ACTIVE;
    localparam int V_ACT0  = V_FP + V_PW + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    mode_e         cfg_mode;
    fmt_e          cfg_fmt;
    rgb_t          cfg_solid;

    logic          h_last, v_last, frame_start, pixel_on, vs_line;
    logic [15:0]   x_raw, y_idx, px;
    rgb_t          pix;
    logic [7:0]    yuv_y, yuv_u, yuv_v;
    logic [7:0]    byte_nxt;

    assign h_last      = (hcnt == HW'(H_TOTAL - 1));
    assign v_last      = (vcnt == VW'(V_TOTAL - 1));
    assign frame_start = (hcnt == '0) && (vcnt == '0);
    // Active lines run to the end of the frame, so only the lower bound needs a compare.
    assign pixel_on    = (hcnt < HW'(2 * H_ACTIVE)) && (vcnt >= VW'(V_ACT0));
    assign vs_line     = (vcnt >= VW'(V_FP)) && (vcnt < VW'(V_FP + V_PW));
    assign x_raw       = 16'(hcnt >> 1);
    assign y_idx       = 16'(vcnt) - 16'(V_ACT0);

`ifdef CAMERA_PATTERN_GEN_SCROLL_EN
    // Tracks FRAME_CNT mod H_ACTIVE incrementally, restarting when the frame counter wraps.
    logic [15:0] scroll_off;
    logic [15:0] x_sum;

    always_ff @(posedge PCLK or negedge ARESETN) begin
        if (!ARESETN)
            scroll_off <= '0;
        else if (ENABLE && h_last && v_last)
            scroll_off <= (FRAME_CNT == 16'hFFFF || scroll_off == 16'(H_ACTIVE - 1))
                          ? 16'd0 : scroll_off + 16'd1;
    end

    assign x_sum = x_raw + scroll_off;
    assign px    = (x_sum >= 16'(H_ACTIVE)) ? x_sum - 16'(H_ACTIVE) : x_sum;
`else
    assign px = x_raw;
`endif

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        pix = '0;
        case (cfg_mode)
            MODE_BARS:    pix = bar_colour(3'(px / 16'(BAR_W)));
            MODE_RAMP:    pix = {px[7:0], px[7:0], px[7:0]};
            MODE_SOLID:   pix = cfg_solid;
            MODE_CHECKER: pix = (((px ^ y_idx) & 16'h0008) != 16'd0) ? 24'hFFFFFF : 24'h000000;
        endcase
    end

    camera_rgb2yuv u_rgb2yuv (
        .rgb (pix),
        .y   (yuv_y),
        .u   (yuv_u),
        .v   (yuv_v)
    );

    // Within each 4-byte pair slot: U(even), Y(even), V(odd), Y(odd); RGB565 alternates high/low.
    always_comb begin
        byte_nxt = '0;
        if (cfg_fmt == FMT_RGB565) begin
            byte_nxt = hcnt[0] ? {pix.g[4:2], pix.b[7:3]} : {pix.r[7:3], pix.g[7:5]};
        end else begin
            case (hcnt[1:0])
                2'd0:    byte_nxt = yuv_u;
                2'd2:    byte_nxt = yuv_v;
                default: byte_nxt = yuv_y;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge PCLK or negedge ARESETN) begin
        if (!ARESETN) begin
            hcnt      <= '0;
            vcnt      <= '0;
            HREF      <= 1'b0;
            VSYNC     <= 1'b0;
            CAMDATA   <= '0;
            FRAME_CNT <= '0;
            cfg_mode  <= MODE_BARS;
            cfg_fmt   <= FMT_YUV422;
            cfg_solid <= '0;
        end else if (!ENABLE) begin
            hcnt    <= '0;
            vcnt    <= '0;
            HREF    <= 1'b0;
            VSYNC   <= 1'b0;
            CAMDATA <= '0;
        end else begin
            if (frame_start) begin
                cfg_mode  <= mode_e'(MODE);
                cfg_fmt   <= fmt_e'(FMT);
                cfg_solid <= SOLID_RGB;
            end
            if (h_last) begin
                hcnt <= '0;
                if (v_last) begin
                    vcnt      <= '0;
                    FRAME_CNT <= FRAME_CNT + 16'd1;
                end else begin
                    vcnt <= vcnt + VW'(1);
                end
            end else begin
                hcnt <= hcnt + HW'(1);
            end
            HREF    <= pixel_on;
            VSYNC   <= vs_line;
            CAMDATA <= pixel_on ? byte_nxt : 8'd0;
        end
    end

endmodule

// File: tb/tb_camera_pattern_gen.sv
// Scoreboard bench for camera_pattern_gen: a frame-position reference model predicts every output cycle.
module tb_camera_pattern_gen;

    localparam int H_ACTIVE  = 32;
    localparam int V_ACTIVE  = 16;
    localparam int H_BLANK   = 8;
    localparam int V_FP      = 2;
    localparam int V_PW      = 2;
    localparam int V_BP      = 2;
    localparam int H_TOTAL   = 2 * H_ACTIVE + H_BLANK;
    localparam int V_ACT0    = V_FP + V_PW + V_BP;
    localparam int V_TOTAL   = V_ACT0 + V_ACTIVE;
    localparam int FRAME_LEN = H_TOTAL * V_TOTAL;

    logic        PCLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        ENABLE = 1'b0;
    logic [1:0]  MODE = 2'b00;
    logic        FMT = 1'b0;
    logic [23:0] SOLID_RGB = '0;
    logic        HREF, VSYNC;
    logic [7:0]  CAMDATA;
    logic [15:0] FRAME_CNT;

    camera_pattern_gen #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .H_BLANK  (H_BLANK),
        .V_FP     (V_FP),
        .V_PW     (V_PW),
        .V_BP     (V_BP)
    ) dut (
        .PCLK      (PCLK),
        .ARESETN   (ARESETN),
        .ENABLE    (ENABLE),
        .MODE      (MODE),
        .FMT       (FMT),
        .SOLID_RGB (SOLID_RGB),
        .HREF      (HREF),
        .VSYNC     (VSYNC),
        .CAMDATA   (CAMDATA),
        .FRAME_CNT (FRAME_CNT)
    );

    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic        href;
        logic        vsync;
        logic [7:0]  data;
        logic [15:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Requested input values, applied on the next falling edge.
    logic [1:0]  d_mode  = 2'b00;
    logic        d_fmt   = 1'b0;
    logic [23:0] d_solid = '0;

    // Reference model state: cycle position inside the frame, frame count, sampled config.
    int pos = 0;
    int m_fc = 0;
    int m_mode = 0;
    int m_fmt = 0;
    int m_solid = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int floor256(input int a);
        return (a >= 0) ? a / 256 : -((-a + 255) / 256);
    endfunction

    function automatic int clampi(input int val, input int lo, input int hi);
        return (val < lo) ? lo : (val > hi) ? hi : val;
    endfunction

    // Byte for pattern column px, active line y, and byte phase (0..3) within the pixel pair.
    function automatic int model_byte(input int px, input int y, input int phase,
                                      input int mode, input int fmt, input int solid);
        int r, g, b, bar, yy, uu, vv;
        r = 0; g = 0; b = 0;
        case (mode)
            0: begin
                bar = px * 8 / H_ACTIVE;
                // white, yellow, cyan, green, magenta, red, blue, black
                r = (bar == 0 || bar == 1 || bar == 4 || bar == 5) ? 255 : 0;
                g = (bar <= 3) ? 255 : 0;
                b = (bar == 0 || bar == 2 || bar == 4 || bar == 6) ? 255 : 0;
            end
            1: begin r = px % 256; g = r; b = r; end
            2: begin r = (solid / 65536) % 256; g = (solid / 256) % 256; b = solid % 256; end
            default: begin r = (((px / 8) + (y / 8)) % 2 == 1) ? 255 : 0; g = r; b = r; end
        endcase
        if (fmt == 1)
            return (phase % 2 == 0) ? (r / 8) * 8 + g / 32 : ((g / 4) % 8) * 32 + b / 8;
        yy = clampi(floor256(66 * r + 129 * g + 25 * b) + 16, 16, 235);
        uu = clampi(floor256(-38 * r - 74 * g + 112 * b) + 128, 16, 240);
        vv = clampi(floor256(112 * r - 94 * g - 18 * b) + 128, 16, 240);
        return (phase == 0) ? uu : (phase == 2) ? vv : yy;
    endfunction

    // Apply one cycle of stimulus and push what the DUT must show after the next rising edge.
    task automatic cycle(input logic rstn, input logic en);
        exp_t e;
        int h, v, px;
        @(negedge PCLK);
        ARESETN   = rstn;
        ENABLE    = en;
        MODE      = d_mode;
        FMT       = d_fmt;
        SOLID_RGB = d_solid;
        e = '0;
        if (!rstn) begin
            pos = 0; m_fc = 0; m_mode = 0; m_fmt = 0; m_solid = 0;
        end else if (!en) begin
            pos  = 0;
            e.fc = 16'(m_fc);
        end else begin
            h = pos % H_TOTAL;
            v = pos / H_TOTAL;
            if (pos == 0) begin
                m_mode = int'(d_mode); m_fmt = int'(d_fmt); m_solid = int'(d_solid);
            end
            px = h / 2;
`ifdef CAMERA_PATTERN_GEN_SCROLL_EN
            px = (px + m_fc) % H_ACTIVE;
`endif
            e.vsync = (v >= V_FP) && (v < V_FP + V_PW);
            e.href  = (h < 2 * H_ACTIVE) && (v >= V_ACT0);
            e.data  = e.href ? 8'(model_byte(px, v - V_ACT0, h % 4, m_mode, m_fmt, m_solid)) : 8'd0;
            pos++;
            if (pos == FRAME_LEN) begin
                pos  = 0;
                m_fc = (m_fc + 1) % 65536;
            end
            e.fc = 16'(m_fc);
        end
        exp_q.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1);
    endtask

    // Advance (bounded) until the model sits at the given line/byte position.
    task automatic run_to(input int hp, input int vp);
        int guard = 0;
        while (!((pos % H_TOTAL) == hp && (pos / H_TOTAL) == vp) && guard < 2 * FRAME_LEN) begin
            cycle(1'b1, 1'b1);
            guard++;
        end
    endtask

    // Monitor: compare each DUT output cycle against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge PCLK);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("href", 32'(HREF), 32'(e.href));
                check("vsync", 32'(VSYNC), 32'(e.vsync));
                check("camdata", 32'(CAMDATA), 32'(e.data));
                check("frame_cnt", 32'(FRAME_CNT), 32'(e.fc));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) cycle(1'b0, 1'b0);
        repeat (2) cycle(1'b1, 1'b0);

        // Bars in YUV; mode switches to checker mid-frame and must only show next frame.
        d_mode = 2'b00; d_fmt = 1'b0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (i == FRAME_LEN / 2) d_mode = 2'b11;
            cycle(1'b1, 1'b1);
        end
        run(FRAME_LEN);

        // Solid orange in RGB565 with mid-frame colour disturbance.
        d_mode = 2'b10; d_fmt = 1'b1; d_solid = 24'hFF8040;
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (i == 700) d_solid = 24'h123456;
            cycle(1'b1, 1'b1);
        end

        // Random configurations, with random mid-frame changes.
        for (int f = 0; f < 8; f++) begin
            d_mode  = 2'($urandom_range(0, 3));
            d_fmt   = 1'($urandom_range(0, 1));
            d_solid = 24'($urandom);
            for (int i = 0; i < FRAME_LEN; i++) begin
                if ($urandom_range(0, 299) == 0) begin
                    d_mode  = 2'($urandom_range(0, 3));
                    d_fmt   = 1'($urandom_range(0, 1));
                    d_solid = 24'($urandom);
                end
                cycle(1'b1, 1'b1);
            end
        end

        // Drop ENABLE mid-line, then restart a full frame.
        d_mode = 2'b01; d_fmt = 1'b0;
        run_to(21, V_ACT0 + 3);
        repeat ($urandom_range(1, 5)) cycle(1'b1, 1'b0);
        run(FRAME_LEN + 100);

        // Asynchronous reset mid-line must clear outputs without waiting for a clock edge.
        run_to(30, V_ACT0 + 5);
        cycle(1'b0, 1'b1);
        #1;
        check("async_reset_href", 32'(HREF), 32'd0);
        check("async_reset_camdata", 32'(CAMDATA), 32'd0);
        check("async_reset_frame_cnt", 32'(FRAME_CNT), 32'd0);
        cycle(1'b0, 1'b1);
        d_mode = 2'b00; d_fmt = 1'b0;
        run(FRAME_LEN + 50);

        repeat (3) @(negedge PCLK);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/camera_pattern_gen.md
CAMERA_PATTERN_GEN -- requirements
Module: camera_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line (even, multiple of 8).
REQ-002 SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 SHALL have parameters H_BLANK=320, V_FP=8, V_PW=4, V_BP=8: blanking in PCLK cycles / lines.
REQ-004 SHALL have ports: PCLK in 1 pixel-byte clock; ARESETN in 1 reset; ENABLE in 1 run.
REQ-005 SHALL have ports: MODE in 2 pattern select; FMT in 1 0=YUV422, 1=RGB565; SOLID_RGB in 24 {R,G,B} for solid mode.
REQ-006 SHALL have ports: HREF out 1; VSYNC out 1; CAMDATA out 8; FRAME_CNT out 16 completed frames.
REQ-007 SHALL use one clock, PCLK; ARESETN is asynchronous, active-low.

Function
REQ-008 SHALL count hcnt 0..2*H_ACTIVE+H_BLANK-1 and vcnt 0..V_FP+V_PW+V_BP+V_ACTIVE-1; vcnt advances when hcnt wraps.
REQ-009 SHALL drive VSYNC=1 exactly for vcnt in [V_FP, V_FP+V_PW), starting at hcnt=0.
REQ-010 SHALL drive HREF=1 for hcnt<2*H_ACTIVE on lines vcnt in [V_FP+V_PW+V_BP, +V_ACTIVE); otherwise 0.
REQ-011 SHALL register all outputs on rising PCLK; CAMDATA byte is valid in the same cycle as HREF; CAMDATA=0 when HREF=0.
REQ-012 SHALL compute pixel x=hcnt/2, y=active line index; each pixel is two bytes.
REQ-013 MODE 00: 8 vertical bars of width H_ACTIVE/8: white, yellow, cyan, green, magenta, red, blue, black (components 255/0).
REQ-014 MODE 01: ramp R=G=B=x[7:0]; MODE 10: SOLID_RGB; MODE 11: 8x8 checker, white when x[3]^y[3]=1, else black.
REQ-015 FMT=0: pixel pair order U(even px), Y(even), V(odd px), Y(odd).
REQ-016 YUV: Y=((66R+129G+25B)>>>8)+16, U=((-38R-74G+112B)>>>8)+128, V=((112R-94G-18B)>>>8)+128; signed, arithmetic shift (floor); clamp Y 16..235, U/V 16..240.
REQ-017 FMT=1: byte0={R[7:3],G[7:5]}, byte1={G[4:2],B[7:3]}.
REQ-018 SHALL sample MODE, FMT, SOLID_RGB only at hcnt=0,vcnt=0; mid-frame changes take effect next frame.
REQ-019 FRAME_CNT SHALL increment when vcnt wraps to 0; wraps 16'hFFFF->0.
REQ-020 ENABLE=0 SHALL synchronously clear hcnt, vcnt, HREF, VSYNC, CAMDATA next cycle; FRAME_CNT holds; ENABLE=1 restarts at hcnt=vcnt=0.

Reset
REQ-021 ARESETN=0 SHALL immediately clear hcnt, vcnt, HREF, VSYNC, CAMDATA, FRAME_CNT and sampled config (MODE=00, FMT=0, SOLID_RGB=0).
REQ-022 Reset mid-line SHALL terminate the frame; first line after release starts at vcnt=0.

Configuration
REQ-023 With CAMERA_PATTERN_GEN_SCROLL_EN defined, pattern x SHALL be (x+FRAME_CNT) mod H_ACTIVE, shifting one pixel left per frame.
REQ-024 Without CAMERA_PATTERN_GEN_SCROLL_EN, pattern x SHALL equal raw x; no scroll logic synthesised.

Structure
REQ-025 Package camera_pkg SHALL hold MODE/FMT encodings, colour-bar RGB table, YUV clamp limits.
REQ-026 Sub-module camera_rgb2yuv SHALL implement REQ-016 as a combinational or one-stage function; generator compensates its latency.

Verification
REQ-027 Reset, defaults, ENABLE=1: HREF rises at vcnt=20,hcnt=0; 1280 HREF cycles per line, 480 lines; VSYNC high lines 8..11.
REQ-028 MODE=00,FMT=0: first pixel pair bytes 128,235,128,235; bar 5 (x=400) bytes 90,81,239,81.
REQ-029 MODE=10,FMT=1,SOLID_RGB=24'hFF8040: every pair 8'hFC,8'h08.
REQ-030 MODE changed 00->11 mid-frame: current frame stays bars; next frame x=8,y=0 is white, x=0,y=0 black.
REQ-031 ENABLE dropped mid-line: HREF/CAMDATA 0 next cycle, FRAME_CNT unchanged; after re-enable, VSYNC at line 8.
REQ-032 SCROLL_EN, MODE=01: at FRAME_CNT=3, first Y byte corresponds to R=G=B=3.
